// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, window types and FSM state encoding for conv_mac_sched.
package conv_pkg;

  localparam int unsigned PIX_W    = 4;
  localparam int unsigned COEF_W   = 5;
  localparam int unsigned PROD_W   = 10;
  localparam int unsigned ACC_W    = 14;
  localparam int unsigned NUM_TAPS = 9;
  localparam int unsigned TAP_W    = 4;

  // Requester identifiers; also the encoding of result_id and the round-robin pointer.
  localparam logic REQ_X = 1'b0;
  localparam logic REQ_Y = 1'b1;

  typedef logic [2:0][2:0][PIX_W-1:0]  pix_win_t;
  typedef logic [2:0][2:0][COEF_W-1:0] coef_win_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/conv_mac_sched_if.sv
// conv_mac_sched_if: request/window bus from the two requesters plus the result bus.
interface conv_mac_sched_if;
  import conv_pkg::*;

  logic             x_req;
  logic             y_req;
  pix_win_t         x_pixels;
  pix_win_t         y_pixels;
  coef_win_t        x_filter;
  coef_win_t        y_filter;
  logic             x_grant;
  logic             y_grant;
  logic             busy;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_id;

  // Requester side.
  modport master (
    output x_req, y_req, x_pixels, y_pixels, x_filter, y_filter,
    input  x_grant, y_grant, busy, result, result_valid, result_id
  );

  // Scheduler side.
  modport slave (
    input  x_req, y_req, x_pixels, y_pixels, x_filter, y_filter,
    output x_grant, y_grant, busy, result, result_valid, result_id
  );

endinterface

// File: rtl/conv_rr_arb.sv
// conv_rr_arb: two-way round-robin pick. i_ptr is the last-served requester
// (0 = X, 1 = Y); on a tie the other one wins, a sole requester always wins.
module conv_rr_arb (
  input  logic i_x_req,
  input  logic i_y_req,
  input  logic i_ptr,
  output logic o_winner,
  output logic o_valid
);

  // Winner select: tie goes away from the pointer, otherwise whoever is asking.
  always_comb begin
    o_valid = i_x_req | i_y_req;
    if (i_x_req && i_y_req) begin
      o_winner = ~i_ptr;
    end else begin
      o_winner = i_y_req;
    end
  end

endmodule

// File: rtl/n_bitmultiplier.sv
// n_bitmultiplier: unsigned N x N combinational multiplier with a 2N-bit product.
module n_bitmultiplier #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  localparam int unsigned PW = 2 * N;

  // Full-width product, operands zero-extended so nothing is truncated.
  always_comb begin
    o_p = PW'(i_a) * PW'(i_b);
  end

endmodule

// File: rtl/conv_mac_sched.sv
// conv_mac_sched: arbitrates two 3x3 convolution requesters onto one shared
// multiplier, one tap per cycle: IDLE -> LOAD -> CALC(9) -> DONE -> IDLE.
// Optional macro CONV_SHIFT_EN: result reports the accumulator shifted right by 2.
module conv_mac_sched
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  conv_mac_sched_if.slave  bus
);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_sel;
  logic              r_ptr;
  logic [TAP_W-1:0]  r_tap;
  logic [PIX_W-1:0]  r_pix  [NUM_TAPS];
  logic [COEF_W-1:0] r_coef [NUM_TAPS];
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_result;

  logic              w_winner;
  logic              w_win_valid;
  logic              w_last_tap;
  pix_win_t          w_pix_sel;
  coef_win_t         w_coef_sel;
  logic [PIX_W-1:0]  w_tap_pix;
  logic [COEF_W-1:0] w_tap_coef;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [ACC_W-1:0]  w_result_next;

  conv_rr_arb u_arb (
    .i_x_req  (bus.x_req),
    .i_y_req  (bus.y_req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_win_valid)
  );

  // Pixels are zero-extended to the coefficient width so one 5x5 multiplier serves both.
  n_bitmultiplier #(
    .N (COEF_W)
  ) u_mult (
    .i_a (COEF_W'(w_tap_pix)),
    .i_b (w_tap_coef),
    .o_p (w_prod)
  );

  assign w_last_tap = (r_tap == TAP_W'(NUM_TAPS - 1));
  assign w_acc_sum  = r_acc + ACC_W'(w_prod);

`ifdef CONV_SHIFT_EN
  assign w_result_next = w_acc_sum >> 2;
`else
  assign w_result_next = w_acc_sum;
`endif

  // Route the selected requester's window toward the capture registers.
  always_comb begin
    w_pix_sel  = (r_sel == REQ_Y) ? bus.y_pixels : bus.x_pixels;
    w_coef_sel = (r_sel == REQ_Y) ? bus.y_filter : bus.x_filter;
  end

  // Pick tap r_tap out of the captured row-major window.
  always_comb begin
    w_tap_pix  = '0;
    w_tap_coef = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (r_tap == TAP_W'(k)) begin
        w_tap_pix  = r_pix[k];
        w_tap_coef = r_coef[k];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake/result outputs; requests only matter in IDLE.
  always_comb begin
    w_state_next     = r_state;
    bus.x_grant      = 1'b0;
    bus.y_grant      = 1'b0;
    bus.busy         = 1'b1;
    bus.result_valid = 1'b0;
    bus.result       = r_result;
    bus.result_id    = r_sel;
    unique case (r_state)
      StIdle: begin
        bus.busy = 1'b0;
        if (w_win_valid) begin
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        bus.x_grant  = (r_sel == REQ_X);
        bus.y_grant  = (r_sel == REQ_Y);
        w_state_next = StCalc;
      end
      StCalc: begin
        if (w_last_tap) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        bus.result_valid = 1'b1;
        w_state_next     = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: latch the winner, capture the window at the grant, accumulate taps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel    <= REQ_X;
      r_ptr    <= REQ_Y;
      r_tap    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_pix[k]  <= '0;
        r_coef[k] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_win_valid) begin
            r_sel <= w_winner;
          end
        end
        StLoad: begin
          for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
              r_pix[i*3+j]  <= w_pix_sel[i][j];
              r_coef[i*3+j] <= w_coef_sel[i][j];
            end
          end
          r_acc <= '0;
          r_tap <= '0;
          r_ptr <= r_sel;
        end
        StCalc: begin
          r_acc <= w_acc_sum;
          r_tap <= r_tap + TAP_W'(1);
          if (w_last_tap) begin
            r_result <= w_result_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_sched.sv
// tb_conv_mac_sched: directed scoreboard bench for conv_mac_sched.
module tb_conv_mac_sched;
  import conv_pkg::*;

`ifdef CONV_SHIFT_EN
  localparam logic [ACC_W-1:0] EXP_A = 14'd1046;
  localparam logic [ACC_W-1:0] EXP_B = 14'd9;
`else
  localparam logic [ACC_W-1:0] EXP_A = 14'd4185;
  localparam logic [ACC_W-1:0] EXP_B = 14'd36;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_mac_sched_if u_if ();

  conv_mac_sched u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct packed {
    logic             id;
    logic [ACC_W-1:0] val;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb_q[$];
  int   vcyc_q[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [ACC_W-1:0] model(input pix_win_t p, input coef_win_t f);
    int sum;
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sum += int'(p[i][j]) * int'(f[i][j]);
      end
    end
`ifdef CONV_SHIFT_EN
    sum = sum / 4;
`endif
    return ACC_W'(sum);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [ACC_W-1:0] v);
    exp_t e;
    e.id  = id;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(input string tag, input int n, input int limit);
    for (int i = 0; i < limit && vcyc_q.size() < n; i++) step();
    chk(tag, 32'(vcyc_q.size() >= n), 1);
  endtask

  task automatic rand_windows();
    u_if.x_pixels = pix_win_t'({$urandom, $urandom});
    u_if.y_pixels = pix_win_t'({$urandom, $urandom});
    u_if.x_filter = coef_win_t'({$urandom, $urandom});
    u_if.y_filter = coef_win_t'({$urandom, $urandom});
  endtask

  // Scoreboard: every result_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (u_if.result_valid === 1'b1) begin
      vcyc_q.push_back(cyc);
      chk("sb_has_entry", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("result", 32'(u_if.result), 32'(mon_e.val));
        chk("result_id", 32'(u_if.result_id), 32'(mon_e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int gid[4];
    int ng;

    rst = 1'b1;
    u_if.x_req = 1'b0;
    u_if.y_req = 1'b0;
    u_if.x_pixels = '0;
    u_if.y_pixels = '0;
    u_if.x_filter = '0;
    u_if.y_filter = '0;

    // Reset state.
    repeat (2) step();
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_valid", 32'(u_if.result_valid), 0);
    chk("rst_result", 32'(u_if.result), 0);
    chk("rst_id", 32'(u_if.result_id), 0);
    chk("rst_xgrant", 32'(u_if.x_grant), 0);
    chk("rst_ygrant", 32'(u_if.y_grant), 0);
    rst = 1'b0;
    step();

    // A: full-scale X job.
    vcyc_q.delete();
    u_if.x_pixels = '1;
    u_if.x_filter = '1;
    push_exp(REQ_X, EXP_A);
    u_if.x_req = 1'b1;
    t0 = cyc;
    step();
    chk("a_xgrant", 32'(u_if.x_grant), 1);
    chk("a_ygrant", 32'(u_if.y_grant), 0);
    chk("a_busy", 32'(u_if.busy), 1);
    u_if.x_req = 1'b0;
    step();
    chk("a_grant_pulse", 32'(u_if.x_grant), 0);
    wait_valid("a_timeout", 1, 20);
    if (vcyc_q.size() > 0) chk("a_latency", 32'(vcyc_q[0] - t0), 11);
    step();
    chk("a_valid_pulse", 32'(u_if.result_valid), 0);
    chk("a_result_held", 32'(u_if.result), 32'(EXP_A));
    chk("a_idle_busy", 32'(u_if.busy), 0);

    // B: Y alone, ramp window with unit filter.
    vcyc_q.delete();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        u_if.y_pixels[i][j] = PIX_W'(i * 3 + j);
        u_if.y_filter[i][j] = COEF_W'(1);
      end
    end
    push_exp(REQ_Y, EXP_B);
    u_if.y_req = 1'b1;
    t0 = cyc;
    step();
    chk("b_ygrant", 32'(u_if.y_grant), 1);
    chk("b_xgrant", 32'(u_if.x_grant), 0);
    u_if.y_req = 1'b0;
    wait_valid("b_timeout", 1, 20);
    if (vcyc_q.size() > 0) chk("b_latency", 32'(vcyc_q[0] - t0), 11);

    // C: both held after reset for four jobs -> X,Y,X,Y every 12 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    vcyc_q.delete();
    rand_windows();
    push_exp(REQ_X, model(u_if.x_pixels, u_if.x_filter));
    push_exp(REQ_Y, model(u_if.y_pixels, u_if.y_filter));
    push_exp(REQ_X, model(u_if.x_pixels, u_if.x_filter));
    push_exp(REQ_Y, model(u_if.y_pixels, u_if.y_filter));
    u_if.x_req = 1'b1;
    u_if.y_req = 1'b1;
    ng = 0;
    for (int i = 0; i < 80 && ng < 4; i++) begin
      step();
      if (u_if.x_grant === 1'b1 || u_if.y_grant === 1'b1) begin
        gid[ng] = (u_if.y_grant === 1'b1) ? 1 : 0;
        ng++;
      end
    end
    u_if.x_req = 1'b0;
    u_if.y_req = 1'b0;
    chk("c_grant_count", 32'(ng), 4);
    for (int k = 0; k < ng; k++) chk("c_order", 32'(gid[k]), 32'(k % 2));
    wait_valid("c_timeout", 4, 60);
    for (int k = 1; k < vcyc_q.size(); k++) chk("c_spacing", 32'(vcyc_q[k] - vcyc_q[k-1]), 12);

    // D: reset during tap 4 aborts the job, then a fresh X job completes.
    step();
    vcyc_q.delete();
    rand_windows();
    u_if.x_req = 1'b1;
    step();
    chk("d_xgrant", 32'(u_if.x_grant), 1);
    u_if.x_req = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("d_abort_busy", 32'(u_if.busy), 0);
    chk("d_abort_valid", 32'(u_if.result_valid), 0);
    chk("d_abort_result", 32'(u_if.result), 0);
    step();
    rst = 1'b0;
    repeat (14) step();
    chk("d_no_valid", 32'(vcyc_q.size()), 0);
    rand_windows();
    push_exp(REQ_X, model(u_if.x_pixels, u_if.x_filter));
    u_if.x_req = 1'b1;
    t0 = cyc;
    step();
    u_if.x_req = 1'b0;
    wait_valid("d_timeout", 1, 20);
    if (vcyc_q.size() > 0) chk("d_latency", 32'(vcyc_q[0] - t0), 11);

    // E: windows scrambled every cycle after the grant; result follows the capture.
    step();
    vcyc_q.delete();
    rand_windows();
    push_exp(REQ_X, model(u_if.x_pixels, u_if.x_filter));
    u_if.x_req = 1'b1;
    step();
    chk("e_xgrant", 32'(u_if.x_grant), 1);
    u_if.x_req = 1'b0;
    for (int i = 0; i < 20 && vcyc_q.size() < 1; i++) begin
      step();
      rand_windows();
    end
    chk("e_done", 32'(vcyc_q.size()), 1);

    step();
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
